// File: rtl/seg_pkg.sv
// Shared definitions for the parking-lot display: digit count, active-low
// 7-segment patterns (bit0 = a) and the BCD conversion state encoding.
package seg_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle,
// BIN_W steps per conversion; a new start is accepted in IDLE or DONE.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int NIBBLES = DIGITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin,
  output logic [4*NIBBLES-1:0] bcd,
  output logic                 busy,
  output logic                 done
);

  localparam int BCD_W = 4 * NIBBLES;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t              state_reg, state_next;
  logic [BCD_W+BIN_W-1:0]   sr_reg, sr_next;
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [BCD_W-1:0]         adj;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib               = sr_reg[BIN_W + 4*gi +: 4];
      assign adj[4*gi +: 4]    = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          sr_next    = {{BCD_W{1'b0}}, bin};
          count_next = CNT_W'(BIN_W);
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        sr_next    = {adj, sr_reg[BIN_W-1:0]} << 1;
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bcd  = sr_reg[BIN_W +: BCD_W];
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment driver with saturating BCD conversion and 2 Hz blink.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the upper digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int VALUE_W = 14,
  parameter int SAT_MAX = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_500Hz,
  input  logic               clk_2Hz,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blink,
  output logic [DIGITS-1:0]  an,
  output logic [6:0]         seg,
  output logic               busy,
  output logic               overflow
);

  localparam logic [VALUE_W-1:0] SAT_VAL = VALUE_W'(SAT_MAX);
  localparam int                 IDX_W   = $clog2(DIGITS);

  logic                conv_busy, conv_done, conv_ready, conv_start;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [VALUE_W-1:0]  start_src, conv_bin;
  logic                start_ovf;
  logic                pending_reg, overflow_reg;
  logic [VALUE_W-1:0]  pending_value_reg;
  logic [3:0]          digit_reg [DIGITS];

  // DONE can accept a fresh start, so a queued load never waits through IDLE.
  assign conv_ready = !conv_busy || conv_done;
  assign conv_start = conv_ready && (load || pending_reg);
  assign start_src  = load ? value : pending_value_reg;
  assign start_ovf  = (start_src > SAT_VAL);
  assign conv_bin   = start_ovf ? SAT_VAL : start_src;

  bin2bcd_seq #(
    .BIN_W   (VALUE_W),
    .NIBBLES (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg       <= 1'b0;
      pending_value_reg <= '0;
      overflow_reg      <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digit_reg[i] <= 4'd0;
    end else begin
      if (load && !conv_ready) begin
        pending_reg       <= 1'b1;
        pending_value_reg <= value;
      end else if (conv_start) begin
        pending_reg <= 1'b0;
      end
      if (conv_start) overflow_reg <= start_ovf;
      if (conv_done) begin
        for (int i = 0; i < DIGITS; i++) digit_reg[i] <= conv_bcd[4*i +: 4];
      end
    end
  end

  logic              clk_500_d_reg, scan_tick;
  logic              started_reg, started_next, blank_now, lead_blank;
  logic [IDX_W-1:0]  idx_reg, disp_idx_reg, disp_idx_next;
  logic [DIGITS-1:0] an_reg, an_next;
  logic [6:0]        seg_reg, seg_next;

  assign scan_tick = clk_500Hz & ~clk_500_d_reg;

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    lead_blank = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (digit_reg[i] == 4'd0);
      if (idx_reg == IDX_W'(i)) lead_blank = zero_above;
    end
  end
`else
  assign lead_blank = 1'b0;
`endif

  // an is recomputed every cycle so blink blanking follows clk_2Hz; seg only moves on a tick.
  always_comb begin
    started_next  = started_reg | scan_tick;
    disp_idx_next = scan_tick ? idx_reg : disp_idx_reg;
    blank_now     = blink & ~clk_2Hz;
    an_next       = '1;
    if (started_next && !blank_now) an_next[disp_idx_next] = 1'b0;
    seg_next = seg_reg;
    if (scan_tick) seg_next = lead_blank ? SEG_BLANK : seg_decode(digit_reg[idx_reg]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_500_d_reg <= 1'b0;
      idx_reg       <= '0;
      disp_idx_reg  <= '0;
      started_reg   <= 1'b0;
      an_reg        <= '1;
      seg_reg       <= SEG_BLANK;
    end else begin
      clk_500_d_reg <= clk_500Hz;
      if (scan_tick) idx_reg <= idx_reg + IDX_W'(1);
      disp_idx_reg  <= disp_idx_next;
      started_reg   <= started_next;
      an_reg        <= an_next;
      seg_reg       <= seg_next;
    end
  end

  assign an       = an_reg;
  assign seg      = seg_reg;
  assign busy     = conv_busy;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver; the scan position is
// predicted from the number of clk_500Hz rises the bench itself generates.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_500Hz;
  logic        clk_2Hz = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy;
  logic        overflow;

  logic        clk_500_man = 1'b0;
  logic        scan_clk = 1'b0;
  logic        scan_en = 1'b0;
  int          half_per = 8;
  int          tog_cnt = 0;
  int          rises = 0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  assign clk_500Hz = scan_en ? scan_clk : clk_500_man;

  seg_scan_driver dut (
    .clk       (clk),
    .reset     (reset),
    .clk_500Hz (clk_500Hz),
    .clk_2Hz   (clk_2Hz),
    .value     (value),
    .load      (load),
    .blink     (blink),
    .an        (an),
    .seg       (seg),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Scan divider model: toggles every half_per cycles, counts its own rising edges.
  initial begin
    forever begin
      @(negedge clk);
      if (!scan_en) begin
        tog_cnt  = 0;
        scan_clk = 1'b0;
        rises    = 0;
      end else begin
        tog_cnt++;
        if (tog_cnt >= half_per) begin
          tog_cnt  = 0;
          scan_clk = !scan_clk;
          if (scan_clk) rises++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int pos);
    logic [3:0] nib;
    nib = d[pos*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && (d >> (pos*4)) == 16'd0) return 7'h7F;
`endif
    return seg_tab[nib];
  endfunction

  task automatic pulse_load(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    $display("load value=%0d", v);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic scan_step(input string tag, input logic [15:0] d);
    logic [3:0] old_an, exp_an;
    int n, pos;
    old_an = an;
    n = 0;
    while (an == old_an && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an == old_an) begin
      check({tag, "_step_timeout"}, 32'd0, 32'd1);
    end else begin
      pos = (rises + 3) % 4;
      exp_an = 4'hF;
      exp_an[pos] = 1'b0;
      check({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
      check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(d, pos)});
      $display("scan %s pos=%0d an=%b seg=%h", tag, pos, an, seg);
    end
  endtask

  task automatic check_display(input string tag, input logic [15:0] d);
    for (int i = 0; i < 4; i++) scan_step(tag, d);
  endtask

  initial begin
    int cnt;

    // Reset held with random inputs
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clk_500_man = 1'($urandom_range(0, 1));
      clk_2Hz     = 1'($urandom_range(0, 1));
      blink       = 1'($urandom_range(0, 1));
      load        = 1'($urandom_range(0, 1));
      value       = 14'($urandom);
      check("rst_an",  {28'd0, an},  32'hF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
    end
    @(negedge clk);
    clk_500_man = 1'b0; clk_2Hz = 1'b0; blink = 1'b0; load = 1'b0; value = '0;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("pre_scan_an",  {28'd0, an},  32'hF);
      check("pre_scan_seg", {25'd0, seg}, 32'h7F);
    end

    // Conversion of 1234 with timing
    scan_en = 1'b1;
    pulse_load(14'd1234);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("conv_busy_c%0d", k + 1), {31'd0, busy}, (k < 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("conv_ovf", {31'd0, overflow}, 32'd0);
    check_display("d1234", 16'h1234);
    scan_step("wrap", 16'h1234);

    // Saturation and recovery
    pulse_load(14'd12000);
    wait_idle("sat");
    check("sat_ovf", {31'd0, overflow}, 32'd1);
    check_display("d9999", 16'h9999);
    pulse_load(14'd7);
    wait_idle("seven");
    check("seven_ovf", {31'd0, overflow}, 32'd0);
    check_display("d0007", 16'h0007);

    // Back-to-back loads with a faster scan so the interim value is visible
    half_per = 1;
    pulse_load(14'd5);
    repeat (2) @(negedge clk);
    pulse_load(14'd100);
    repeat (2) @(negedge clk);
    pulse_load(14'd250);
    repeat (10) @(negedge clk);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check_display("d0005", 16'h0005);
    wait_idle("b2b");
    check_display("d0250", 16'h0250);
    half_per = 8;

    // Blink
    blink = 1'b1; clk_2Hz = 1'b0;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an != 4'hF) cnt++;
    end
    check("blink_low_lit", cnt, 0);
    clk_2Hz = 1'b1;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (an == 4'hF) cnt++;
    end
    check("blink_high_dark", cnt, 0);
    blink = 1'b0; clk_2Hz = 1'b0;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (an == 4'hF) cnt++;
    end
    check("noblink_dark", cnt, 0);
    scan_step("after_blink", 16'h0250);

    // Reset during conversion with a pending load
    pulse_load(14'd12000);
    repeat (5) @(negedge clk);
    pulse_load(14'd500);
    check("mid_ovf_set", {31'd0, overflow}, 32'd1);
    scan_en = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mid_rst_an",  {28'd0, an},  32'hF);
      check("mid_rst_seg", {25'd0, seg}, 32'h7F);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    scan_en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("post_rst_busy", cnt, 0);
    check("post_rst_ovf", {31'd0, overflow}, 32'd0);
    check_display("d0000", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
